reset_request_sequencer: RTL and testbench
==========================================

Name: reset_request_sequencer

Overview:
- Initiator side of the reset-sync path: drives a reset request into a target domain's catch-and-sync synchronizer, then watches that domain's synchronized reset coming back.
- Enforces a minimum assertion width and a two-phase handshake (assert ack, release ack), with a timeout on each phase.
- Sits in the always-on clock domain, driven by debug or power-management control logic.

Parameters:
- HOLD_CYCLES, 8: minimum number of cycles io_reset_out stays high; must be >= 1.
- ACK_TIMEOUT, 64: cycles allowed in a wait phase before error; must be > HOLD_CYCLES.
- CNT_W, 8: width of the hold and timeout counters; must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- clock  in  1  block clock.
- reset  in  1  synchronous, active-high reset.
- io_req  in  1  start a reset sequence; sampled each cycle.
- io_clear  in  1  clears the ERROR state.
- io_sync_reset_in  in  1  target domain's synchronized reset, already re-synchronized into this clock domain.
- io_reset_out  out  1  registered reset request to the target's asynchronous reset input.
- io_busy  out  1  high in ASSERT, RELEASE, DONE.
- io_done  out  1  one-cycle pulse when a sequence completes.
- io_error  out  1  high while in ERROR.
- io_error_phase  out  1  0 = assert-ack timeout, 1 = release-ack timeout; valid while io_error=1.

Behaviour:
- One clock domain. Reset is synchronous and active-high (port names: clock, reset).
- All outputs are registered. During and after reset: state=IDLE, all outputs 0, counters 0, ack_seen=0.
- IDLE:
  - io_reset_out=0.
  - io_req=1 sampled at edge k -> ASSERT from edge k+1; io_reset_out=1 in the same cycle.
- ASSERT:
  - io_reset_out=1.
  - hold_cnt counts cycles spent in ASSERT.
  - ack_seen is set the first time io_sync_reset_in=1 and stays set.
  - Exit to RELEASE when hold_cnt reaches HOLD_CYCLES and ack_seen (or io_sync_reset_in) is 1.
  - If the ack is present from entry, io_reset_out is high for exactly HOLD_CYCLES cycles.
  - Timeout: if the ack has not been seen after ACK_TIMEOUT cycles in ASSERT, go to ERROR with phase=0.
- RELEASE:
  - io_reset_out=0; tmo_cnt is reloaded on entry.
  - First cycle with io_sync_reset_in=0 -> DONE next edge.
  - After ACK_TIMEOUT cycles without that -> ERROR with phase=1.
- DONE:
  - io_done=1 for exactly one cycle, then IDLE.
  - A new io_req is accepted only once back in IDLE, unless the optional feature is enabled.
- ERROR:
  - io_reset_out=0, io_error=1, io_busy=0; io_req is ignored.
  - io_clear=1 -> IDLE next edge.
  - If io_clear and io_req are high together, clear wins and the request is dropped.
- io_req in ASSERT, RELEASE or DONE is ignored; no queueing.
- io_clear outside ERROR has no effect.
- Counters saturate and never wrap; the timeout compare uses cycles-in-state == ACK_TIMEOUT.
- io_sync_reset_in is treated as already synchronized; this block adds no synchronizer.
- reset asserted mid-sequence: the next edge forces IDLE with io_reset_out=0 and no io_done pulse; the sticky error is cleared.

Optional Feature:
- Macro: RESET_SEQ_PENDING_EN.
- Defined:
  - A one-deep pending flag is set by io_req while in ASSERT, RELEASE or DONE.
  - DONE then goes directly to ASSERT instead of IDLE, io_done still pulses, and the flag clears.
  - ERROR and reset both clear the flag.
- Undefined: requests while busy are dropped and no pending flag exists.

Test Plan:
- Basic sequence:
  - Stimulus: io_req pulse at cycle 10; io_sync_reset_in rises at cycle 13 and falls 3 cycles after io_reset_out falls.
  - Response: io_reset_out high cycles 11–18 (8 cycles); io_done pulses at cycle 23; io_busy high 11–23.
- Slow assert ack:
  - Stimulus: io_sync_reset_in rises 20 cycles after io_reset_out rises.
  - Response: io_reset_out stays high 21 cycles, then the normal release completes with io_done=1.
- Assert timeout:
  - Stimulus: io_sync_reset_in held 0.
  - Response: 64 cycles after ASSERT entry, io_error=1 and io_error_phase=0, io_reset_out=0; io_req then ignored; io_clear -> IDLE; a following io_req starts a fresh sequence.
- Release timeout:
  - Stimulus: io_sync_reset_in stuck at 1.
  - Response: ERROR with phase=1 after 64 cycles in RELEASE.
- Reset mid-ASSERT:
  - Stimulus: reset pulse at the 4th ASSERT cycle.
  - Response: io_reset_out=0 and io_busy=0 at the next edge; no io_done pulse.
- Request while busy:
  - Stimulus: io_req during RELEASE.
  - Response without the macro: ignored, a single io_done.
  - Response with RESET_SEQ_PENDING_EN: a second ASSERT starts immediately after DONE and two io_done pulses are seen.

Source files
------------

// File: rtl/reset_request_sequencer.sv
// reset_request_sequencer
//
// Initiator side of a reset-sync path, in the always-on clock domain.
// It drives a reset request into a target domain and waits for that
// domain's synchronized reset to come back. It then releases the request
// and waits for the synchronized reset to drop again. Each wait phase has
// a timeout that leads to a sticky ERROR state, and only io_clear leaves it.
//
// Parameters:
//   HOLD_CYCLES  minimum number of cycles io_reset_out stays high (>= 1)
//   ACK_TIMEOUT  cycles allowed in a wait phase before error (> HOLD_CYCLES)
//   CNT_W        counter width, 2**CNT_W > ACK_TIMEOUT
//
// Ports:
//   clock             block clock
//   reset             synchronous, active-high reset
//   io_req            start a reset sequence (sampled each cycle)
//   io_clear          leave the ERROR state
//   io_sync_reset_in  target's synchronized reset, already in this domain
//   io_reset_out      registered reset request to the target
//   io_busy           high in ASSERT, RELEASE, DONE
//   io_done           one-cycle pulse when a sequence completes
//   io_error          high while in ERROR
//   io_error_phase    0 = assert-ack timeout, 1 = release-ack timeout
//
// Optional build macro RESET_SEQ_PENDING_EN adds a one-deep pending flag.
// A request that arrives while the block is busy sets this flag. DONE then
// restarts ASSERT directly instead of returning to IDLE.
//
// state   | meaning
// IDLE    | waiting for io_req, reset request low
// ASSERT  | reset request high, waiting for min width and ack
// RELEASE | reset request low, waiting for synchronized reset to drop
// DONE    | one-cycle completion pulse
// ERROR   | a wait phase timed out, held until io_clear

module reset_request_sequencer #(
    parameter int HOLD_CYCLES = 8,
    parameter int ACK_TIMEOUT = 64,
    parameter int CNT_W       = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic io_req,
    input  logic io_clear,
    input  logic io_sync_reset_in,
    output logic io_reset_out,
    output logic io_busy,
    output logic io_done,
    output logic io_error,
    output logic io_error_phase
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT,
        S_RELEASE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] tmo_cnt;
    logic             ack_seen;
    logic             ack_now;
    logic             restart;

    // An ack arriving in the current cycle counts right away, so exit is
    // not delayed by a cycle waiting for ack_seen to register it.
    assign ack_now = ack_seen | io_sync_reset_in;

`ifdef RESET_SEQ_PENDING_EN
    logic pending;

    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (state == S_DONE || state == S_ERROR) begin
            pending <= 1'b0;
        end else if (io_req && (state == S_ASSERT || state == S_RELEASE)) begin
            pending <= 1'b1;
        end
    end

    // A request that lands in the DONE cycle itself is consumed immediately.
    assign restart = pending | io_req;
`else
    assign restart = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            hold_cnt       <= '0;
            tmo_cnt        <= '0;
            ack_seen       <= 1'b0;
            io_reset_out   <= 1'b0;
            io_busy        <= 1'b0;
            io_done        <= 1'b0;
            io_error       <= 1'b0;
            io_error_phase <= 1'b0;
        end else begin
            io_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (io_req) begin
                        state        <= S_ASSERT;
                        hold_cnt     <= CNT_ONE;
                        ack_seen     <= 1'b0;
                        io_reset_out <= 1'b1;
                        io_busy      <= 1'b1;
                    end
                end

                // hold_cnt holds the 1-based index of the current ASSERT cycle.
                S_ASSERT: begin
                    ack_seen <= ack_now;
                    if (hold_cnt != CNT_MAX) begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                    end
                    if (ack_now && hold_cnt >= HOLD_C) begin
                        state        <= S_RELEASE;
                        tmo_cnt      <= CNT_ONE;
                        io_reset_out <= 1'b0;
                    end else if (!ack_now && hold_cnt == TMO_C) begin
                        state          <= S_ERROR;
                        io_reset_out   <= 1'b0;
                        io_busy        <= 1'b0;
                        io_error       <= 1'b1;
                        io_error_phase <= 1'b0;
                    end
                end

                // A drop in the final allowed cycle still completes normally.
                S_RELEASE: begin
                    if (!io_sync_reset_in) begin
                        state   <= S_DONE;
                        io_done <= 1'b1;
                    end else if (tmo_cnt == TMO_C) begin
                        state          <= S_ERROR;
                        io_busy        <= 1'b0;
                        io_error       <= 1'b1;
                        io_error_phase <= 1'b1;
                    end else if (tmo_cnt != CNT_MAX) begin
                        tmo_cnt <= tmo_cnt + CNT_ONE;
                    end
                end

                S_DONE: begin
                    if (restart) begin
                        state        <= S_ASSERT;
                        hold_cnt     <= CNT_ONE;
                        ack_seen     <= 1'b0;
                        io_reset_out <= 1'b1;
                    end else begin
                        state   <= S_IDLE;
                        io_busy <= 1'b0;
                    end
                end

                // A clear always wins; a request in the same cycle is dropped.
                S_ERROR: begin
                    if (io_clear) begin
                        state          <= S_IDLE;
                        io_error       <= 1'b0;
                        io_error_phase <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_request_sequencer.sv
// Testbench for reset_request_sequencer.
//
// The stimulus side plays the target domain. Its synchronized reset rises
// d_a cycles after the request rises, and falls d_r cycles after the
// request falls. From these two delays the reference model works out the
// cycle of every output change. It pushes each change into a queue as a
// (cycle, output vector) pair. A free-running monitor watches the output
// vector and pops one entry each time the vector changes.
module tb_reset_request_sequencer;

    localparam int HOLD = 8;
    localparam int TMO  = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic io_req = 1'b0;
    logic io_clear = 1'b0;
    logic io_sync_reset_in = 1'b0;
    logic io_reset_out, io_busy, io_done, io_error, io_error_phase;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [4:0] vec;
    } exp_t;

    exp_t       exp_q[$];
    logic [4:0] prev_vec = '0;
    bit         mon_en = 1'b0;

    reset_request_sequencer #(
        .HOLD_CYCLES(HOLD),
        .ACK_TIMEOUT(TMO),
        .CNT_W(8)
    ) dut (
        .clock(clk),
        .reset(reset),
        .io_req(io_req),
        .io_clear(io_clear),
        .io_sync_reset_in(io_sync_reset_in),
        .io_reset_out(io_reset_out),
        .io_busy(io_busy),
        .io_done(io_done),
        .io_error(io_error),
        .io_error_phase(io_error_phase)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output vector {reset_out, busy, done, error, phase}.
    // The phase bit only means something while error is high, so it is masked otherwise.
    function automatic logic [4:0] out_vec();
        return {io_reset_out, io_busy, io_done, io_error, io_error & io_error_phase};
    endfunction

    function automatic void expect_at(int c, logic [4:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        logic [4:0] cur;
        exp_t       e;
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missed_change cycle=%0d got=%b want=%b@%0d",
                         cyc, out_vec(), e.vec, e.cyc);
            end
            cur = out_vec();
            if (cur != prev_vec) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change cycle=%0d got=%b want=%b (no change)",
                             cyc, cur, prev_vec);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.vec != cur) begin
                        n_fail++;
                        $display("FAIL out_change cycle=%0d got=%b want=%b@%0d",
                                 cyc, cur, e.vec, e.cyc);
                    end
                end
            end
            prev_vec = cur;
        end
    end

    task automatic idle(int n);
        io_req = 1'b0;
        io_clear = 1'b0;
        io_sync_reset_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Starts a sequence with a request issued in the current cycle.
    // A delay d_a >= TMO means the ack never rises.
    // A delay d_r >= TMO means the synchronized reset never falls.
    // If busy_req is set, io_req is also driven in the first RELEASE cycle.
    task automatic run_seq(int d_a, int d_r, bit busy_req);
        int a[2];
        int r[2];
        int dn[2];
        int n;
        int l;
        int last;
        bit err;
        bit s;
        n = 1;
        err = 1'b0;
`ifdef RESET_SEQ_PENDING_EN
        if (busy_req) n = 2;
`endif
        io_req = 1'b1;
        io_clear = 1'b0;
        io_sync_reset_in = 1'b0;
        a[0] = cyc + 1;
        a[1] = 0; r[1] = 0; dn[1] = 0;
        l = (d_a + 1 > HOLD) ? d_a + 1 : HOLD;
        if (d_a >= TMO) begin
            r[0] = a[0] + TMO;
            dn[0] = 0;
            expect_at(a[0], 5'b11000);
            expect_at(a[0] + TMO, 5'b00010);
            last = a[0] + TMO - 1;
            err = 1'b1;
        end else if (d_r >= TMO) begin
            r[0] = a[0] + l;
            dn[0] = 0;
            expect_at(a[0], 5'b11000);
            expect_at(r[0], 5'b01000);
            expect_at(r[0] + TMO, 5'b00011);
            last = r[0] + TMO - 1;
            err = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) begin
                if (i > 0) a[i] = dn[i-1] + 1;
                r[i]  = a[i] + l;
                dn[i] = r[i] + d_r + 1;
                expect_at(a[i], 5'b11000);
                expect_at(r[i], 5'b01000);
                expect_at(dn[i], 5'b01100);
            end
            expect_at(dn[n-1] + 1, 5'b00000);
            last = dn[n-1];
        end

        for (int cur = a[0]; cur <= last; cur++) begin
            @(negedge clk);
            io_req = busy_req && (cur == r[0]);
`ifndef RESET_SEQ_PENDING_EN
            if ($urandom_range(0, 4) == 0) io_req = 1'b1;
`endif
            io_clear = ($urandom_range(0, 4) == 0);
            s = 1'b0;
            for (int i = 0; i < n; i++)
                if (d_a < TMO && cur >= a[i] + d_a && cur < r[i] + d_r) s = 1'b1;
            io_sync_reset_in = s;
        end
        @(negedge clk);
        io_req = 1'b0;
        io_clear = 1'b0;
        io_sync_reset_in = 1'b0;

        if (err) begin
            // While in ERROR, requests must be ignored. A clear that comes
            // together with a request must still win.
            repeat ($urandom_range(2, 5)) begin
                io_req = ($urandom_range(0, 1) == 1);
                @(negedge clk);
            end
            io_clear = 1'b1;
            io_req = ($urandom_range(0, 1) == 1);
            expect_at(cyc + 1, 5'b00000);
            @(negedge clk);
            io_clear = 1'b0;
            io_req = 1'b0;
        end
    endtask

    // Pulses reset during the 4th ASSERT cycle.
    task automatic run_reset_mid();
        int a;
        io_req = 1'b1;
        a = cyc + 1;
        expect_at(a, 5'b11000);
        expect_at(a + 4, 5'b00000);
        for (int cur = a; cur <= a + 3; cur++) begin
            @(negedge clk);
            io_req = 1'b0;
            io_clear = 1'b0;
            io_sync_reset_in = (cur >= a + 1);
            reset = (cur == a + 3);
        end
        @(negedge clk);
        reset = 1'b0;
        io_sync_reset_in = 1'b0;
    endtask

    initial begin
        int kind;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_vec() != 5'b00000) begin
            n_fail++;
            $display("FAIL reset_state got=%b want=%b", out_vec(), 5'b00000);
        end
        prev_vec = out_vec();
        mon_en = 1'b1;
        reset = 1'b0;
        while (cyc < 10) @(negedge clk);

        run_seq(2, 3, 1'b0);          // basic: request at cycle 10, done at 23
        idle(3);
        run_seq(20, 2, 1'b0);         // slow assert ack: 21 high cycles
        idle(2);
        run_seq(TMO, 0, 1'b0);        // assert timeout
        idle(2);
        run_seq(0, TMO, 1'b0);        // release timeout
        idle(2);
        run_reset_mid();
        idle(3);
        run_seq(3, 2, 1'b1);          // request while busy
        idle(2);
        run_seq(TMO - 1, 1, 1'b0);    // ack in the last allowed assert cycle
        run_seq(HOLD - 1, TMO - 1, 1'b0); // drop in the last allowed release cycle
        run_seq(HOLD, 0, 1'b0);
        run_seq(0, 0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0)
                run_seq(TMO, 0, 1'b0);
            else if (kind == 1)
                run_seq($urandom_range(0, 30), TMO, 1'b0);
            else
                run_seq($urandom_range(0, 40), $urandom_range(0, 12),
                        ($urandom_range(0, 2) == 0));
            idle($urandom_range(0, 3));
        end

        idle(6);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained got=%0d pending entries want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
